// File: rtl/elastic_pipe.sv
// Stallable L-stage valid/ready register pipeline with an input skid register; bubbles collapse.
// Latency: L cycles from input acceptance to d_valid when unstalled; throughput 1 beat/cycle.
// Backpressure: d_ready stalls stages from the output back; s_ready is a flop that drops only while the skid holds a beat.
// Optional build macro ELASTIC_PIPE_FLUSH_EN adds a synchronous flush input that empties the pipe.
module elastic_pipe #(
    parameter  int DW = 8,
    parameter  int L  = 4,
    localparam int CW = $clog2(L + 2)
) (
    input  logic          clk,
    input  logic          rst,
`ifdef ELASTIC_PIPE_FLUSH_EN
    input  logic          flush,
`endif
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          d_valid,
    input  logic          d_ready,
    output logic [DW-1:0] d_data,
    output logic [CW-1:0] count
);

    // Stage state: v_q[i] marks stage i occupied, data_q[i] its payload.
    logic [L-1:0]  v_q;
    logic [L-1:0]  v_d;
    logic [DW-1:0] data_q [L];
    logic [DW-1:0] data_d [L];

    // Skid register absorbs the beat accepted on the cycle stage 0 could not move.
    logic          skid_full_q;
    logic          skid_full_d;
    logic [DW-1:0] skid_data_q;
    logic [DW-1:0] skid_data_d;

    logic          s_ready_q;
    logic          s_ready_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic [L-1:0]  adv;
    logic          in_xfer;
    logic          out_xfer;
    logic          src_v;
    logic [DW-1:0] src_d;
    logic          flush_i;

`ifdef ELASTIC_PIPE_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    assign in_xfer  = s_valid & s_ready_q;
    assign out_xfer = v_q[L-1] & d_ready;

    assign s_ready  = s_ready_q;
    assign d_valid  = v_q[L-1];
    assign d_data   = data_q[L-1];
    assign count    = count_q;

    // Advance enables: a stage may load when the output drains or any stage at or after it is empty.
    always_comb begin : adv_calc
        logic go;
        go  = d_ready;
        adv = '0;
        for (int i = L - 1; i >= 0; i--) begin
            go     = go | ~v_q[i];
            adv[i] = go;
        end
    end

    // Stage-0 source: a held skid beat takes priority over the live input.
    always_comb begin
        src_v = skid_full_q | in_xfer;
        src_d = skid_full_q ? skid_data_q : s_data;
    end

    // Stage moves: advancing stages copy their upstream neighbour; data only updates on a valid source.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (adv[0]) begin
            v_d[0] = src_v;
            if (src_v) begin
                data_d[0] = src_d;
            end
        end
        for (int i = 1; i < L; i++) begin
            if (adv[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    data_d[i] = data_q[i-1];
                end
            end
        end
        if (flush_i) begin
            v_d = '0;
        end
    end

    // Skid fill/drain, registered ready and occupancy count.
    always_comb begin
        skid_full_d = skid_full_q;
        skid_data_d = skid_data_q;
        if (skid_full_q && adv[0]) begin
            skid_full_d = 1'b0;
        end else if (in_xfer && !adv[0]) begin
            skid_full_d = 1'b1;
            skid_data_d = s_data;
        end
        if (flush_i) begin
            skid_full_d = 1'b0;
        end
        s_ready_d = ~skid_full_d;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_xfer) - CW'(out_xfer);
        end
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < L; i++) begin
                data_q[i] <= '0;
            end
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            s_ready_q   <= 1'b1;
            count_q     <= '0;
        end else begin
            v_q         <= v_d;
            data_q      <= data_d;
            skid_full_q <= skid_full_d;
            skid_data_q <= skid_data_d;
            s_ready_q   <= s_ready_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_elastic_pipe.sv
// Self-checking bench for elastic_pipe: directed latency/stream/backpressure/reset scenarios
// plus a randomized run against a queue-based reference model.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_elastic_pipe;
    localparam int DW = 8;
    localparam int L  = 4;
    localparam int CW = $clog2(L + 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          d_valid;
    logic          d_ready;
    logic [DW-1:0] d_data;
    logic [CW-1:0] count;
`ifdef ELASTIC_PIPE_FLUSH_EN
    logic          flush;
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];

    elastic_pipe #(.DW(DW), .L(L)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef ELASTIC_PIPE_FLUSH_EN
        .flush   (flush),
`endif
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_data  (d_data),
        .count   (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Push beats with d_ready low until s_ready drops; returns how many were accepted.
    task automatic fill_pipe(input logic [DW-1:0] base, output int n);
        n = 0;
        d_ready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (s_ready !== 1'b1) break;
            s_valid = 1'b1;
            s_data  = base + DW'(n);
            n++;
            @(negedge clk);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; s_data = '0; d_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL reset_dvalid: got %b want 0", d_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready: got %b want 1", s_ready); end
        checks++; if (d_data !== '0) begin errors++; $display("FAIL reset_ddata: got %h want 00", d_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (d_valid !== 1'b0 || s_ready !== 1'b1 || count !== '0) begin
            errors++; $display("FAIL post_reset: dv=%b sr=%b cnt=%0d want 0 1 0", d_valid, s_ready, count);
        end
    endtask

    task automatic test_latency();
        logic exp_v;
        s_valid = 1'b1; s_data = 8'hA5; d_ready = 1'b1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL lat_sready: got %b want 1", s_ready); end
        @(negedge clk);
        s_valid = 1'b0; s_data = 8'h00;
        for (int k = 1; k <= L + 2; k++) begin
            exp_v = (k == L);
            checks++; if (d_valid !== exp_v) begin errors++; $display("FAIL lat_dvalid k=%0d: got %b want %b", k, d_valid, exp_v); end
            if (k == L) begin
                checks++; if (d_data !== 8'hA5) begin errors++; $display("FAIL lat_ddata: got %h want a5", d_data); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_streaming();
        int sent = 0;
        int rcvd = 0;
        d_ready = 1'b1;
        for (int c = 0; c < 100 + L + 20 && rcvd < 100; c++) begin
            s_valid = (sent < 100);
            s_data  = DW'(sent);
            if (sent < 100) begin
                checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_sready c=%0d: got %b want 1", c, s_ready); end
            end
            if (rcvd > 0 && rcvd < 100) begin
                checks++; if (d_valid !== 1'b1) begin errors++; $display("FAIL stream_gap rcvd=%0d: got %b want 1", rcvd, d_valid); end
            end
            if (d_valid === 1'b1) begin
                checks++; if (d_data !== DW'(rcvd)) begin errors++; $display("FAIL stream_data: got %h want %h", d_data, DW'(rcvd)); end
                rcvd++;
            end
            if (s_valid && s_ready === 1'b1) sent++;
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++; if (rcvd != 100) begin errors++; $display("FAIL stream_total: got %0d want 100", rcvd); end
    endtask

    task automatic test_backpressure();
        int n;
        int got = 0;
        int rdy_at = -1;
        fill_pipe(8'h30, n);
        checks++; if (n != L + 1) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", n, L + 1); end
        checks++; if (count !== CW'(L + 1)) begin errors++; $display("FAIL bp_count: got %0d want %0d", count, L + 1); end
        checks++; if (d_valid !== 1'b1 || d_data !== 8'h30) begin errors++; $display("FAIL bp_head: dv=%b d=%h want 1 30", d_valid, d_data); end
        d_ready = 1'b1;
        for (int c = 0; c < L + 10; c++) begin
            if (s_ready === 1'b1 && rdy_at < 0) rdy_at = c;
            if (d_valid === 1'b1) begin
                checks++; if (d_data !== 8'h30 + DW'(got)) begin errors++; $display("FAIL bp_order: got %h want %h", d_data, 8'h30 + DW'(got)); end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != L + 1) begin errors++; $display("FAIL bp_drained: got %0d want %0d", got, L + 1); end
        checks++; if (rdy_at < 0 || rdy_at > 2) begin errors++; $display("FAIL bp_sready_return: got cycle %0d want 0..2", rdy_at); end
    endtask

    task automatic test_reset_full();
        int n;
        fill_pipe(8'h50, n);
        #2 rst = 1'b1;
        #1;
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL rstfull_dvalid: got %b want 0", d_valid); end
        checks++; if (count !== '0) begin errors++; $display("FAIL rstfull_count: got %0d want 0", count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstfull_sready: got %b want 1", s_ready); end
        @(negedge clk);
        rst = 1'b0;
        d_ready = 1'b1;
        repeat (L + 2) @(negedge clk);
        checks++; if (d_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL rstfull_stale: dv=%b cnt=%0d want 0 0", d_valid, count); end
    endtask

    task automatic test_random();
        logic          prev_hold = 1'b0;
        logic [DW-1:0] prev_dat  = '0;
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = DW'($urandom);
            d_ready = 1'($urandom_range(0, 1));
            checks++; if (count !== CW'(sb.size())) begin errors++; $display("FAIL rand_count c=%0d: got %0d want %0d", c, count, sb.size()); end
            checks++; if (s_ready !== (sb.size() < L + 1)) begin errors++; $display("FAIL rand_sready c=%0d: got %b want %b", c, s_ready, sb.size() < L + 1); end
            if (d_valid === 1'b1) begin
                checks++; if (sb.size() == 0 || d_data !== sb[0]) begin
                    errors++; $display("FAIL rand_data c=%0d: got %h want %h", c, d_data, (sb.size() == 0) ? 8'h00 : sb[0]);
                end
            end
            if (prev_hold) begin
                checks++; if (d_valid !== 1'b1 || d_data !== prev_dat) begin
                    errors++; $display("FAIL rand_hold c=%0d: dv=%b d=%h want 1 %h", c, d_valid, d_data, prev_dat);
                end
            end
            prev_hold = d_valid & ~d_ready;
            prev_dat  = d_data;
            if (d_valid === 1'b1 && d_ready && sb.size() > 0) void'(sb.pop_front());
            if (s_valid && s_ready === 1'b1) sb.push_back(s_data);
            @(negedge clk);
        end
        s_valid = 1'b0;
        d_ready = 1'b1;
        for (int c = 0; c < L + 6; c++) begin
            if (d_valid === 1'b1) begin
                checks++; if (sb.size() == 0 || d_data !== sb[0]) begin errors++; $display("FAIL rand_drain: got %h", d_data); end
                if (sb.size() > 0) void'(sb.pop_front());
            end
            @(negedge clk);
        end
        checks++; if (sb.size() != 0 || count !== '0) begin errors++; $display("FAIL rand_empty: left=%0d cnt=%0d want 0 0", sb.size(), count); end
    endtask

`ifdef ELASTIC_PIPE_FLUSH_EN
    task automatic test_flush();
        bit seen = 0;
        d_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_data = 8'h60 + DW'(i);
            @(negedge clk);
        end
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1; s_data = 8'hEE;
        @(negedge clk);
        flush = 1'b0; s_valid = 1'b0;
        checks++; if (count !== '0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL flush_dvalid: got %b want 0", d_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL flush_sready: got %b want 1", s_ready); end
        d_ready = 1'b1;
        for (int c = 0; c < L + 3; c++) begin
            checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL flush_leak: got dv=%b d=%h want 0", d_valid, d_data); end
            @(negedge clk);
        end
        s_valid = 1'b1; s_data = 8'h77;
        @(negedge clk);
        s_valid = 1'b0;
        for (int c = 0; c < L + 3; c++) begin
            if (d_valid === 1'b1 && d_data === 8'h77) seen = 1;
            @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL flush_recover: beat 77 not seen"); end
    endtask
`endif

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; d_ready = 1'b0;
`ifdef ELASTIC_PIPE_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_latency();
        test_streaming();
        test_backpressure();
        test_reset_full();
        test_random();
`ifdef ELASTIC_PIPE_FLUSH_EN
        test_flush();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
